// File: rtl/fast_pkg.sv
// Shared field layout of the FAST patch word and the keypoint word.
package fast_pkg;

  localparam int PATCH_W    = 34;
  localparam int KP_W       = 33;
  localparam int COORD_W    = 10;
  localparam int SCORE_W    = 13;
  localparam int X_MSB      = 33;
  localparam int Y_MSB      = 23;
  localparam int CORNER_BIT = 13;

  typedef logic [KP_W-1:0] kp_t;

  // Unsigned corner score carried in the low bits of a patch word.
  function automatic logic [SCORE_W-1:0] score_of(input logic [PATCH_W-1:0] w);
    return w[SCORE_W-1:0];
  endfunction

  // Repack a patch word into {x, y, score}, dropping the corner flag.
  function automatic kp_t kp_of(input logic [PATCH_W-1:0] w);
    return {w[X_MSB -: COORD_W], w[Y_MSB -: COORD_W], w[SCORE_W-1:0]};
  endfunction

endpackage

// File: rtl/nms_select_kp_fifo.sv
// Keypoint FIFO with registered head. Occupancy includes the output register,
// so DEPTH keypoints can be held in total. Storage has no reset.
module kp_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             do_push, do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = dout_q;
  assign valid_o = valid_q;

  // Next pointers and next head; a write landing on the new head bypasses memory.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
    valid_d = (wr_d != rd_d);
    if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
      dout_d = din_i;
    end else begin
      dout_d = mem_q[rd_d[AW-1:0]];
    end
  end

  // Storage write; contents are only ever read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

  // Pointer, head-valid and head-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      if (valid_d) begin
        dout_q <= dout_d;
      end
    end
  end

endmodule

// File: rtl/nms_select.sv
// 3x3 non-maximum suppression: the centre corner survives only if it beats its
// neighbours (strictly for the upper-left half, or-equal for the lower-right half),
// then flows through a two-stage ce-gated pipeline into a keypoint FIFO.
module nms_select
  import fast_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               nms_vld,
  input  logic [PATCH_W-1:0] o00,
  input  logic [PATCH_W-1:0] o01,
  input  logic [PATCH_W-1:0] o02,
  input  logic [PATCH_W-1:0] o10,
  input  logic [PATCH_W-1:0] o11,
  input  logic [PATCH_W-1:0] o12,
  input  logic [PATCH_W-1:0] o20,
  input  logic [PATCH_W-1:0] o21,
  input  logic [PATCH_W-1:0] o22,
  input  logic               frame_clr,
  output logic [KP_W-1:0]    kp_data,
  output logic               kp_valid,
  input  logic               kp_ready,
  output logic [CNT_W-1:0]   kp_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               overflow
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  logic [SCORE_W-1:0] c_s;
  logic               surv;
  logic               vld_p1_q, vld_p2_q;
  kp_t                kp_p1_q, kp_p2_q;
  logic               push, pop, drop, accept;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   kp_cnt_q, kp_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               ovf_q, ovf_d;
  logic               unused_bits;

  // Neighbour coordinates and corner flags take no part in the decision.
  assign unused_bits = ^{o00[PATCH_W-1:SCORE_W], o01[PATCH_W-1:SCORE_W],
                         o02[PATCH_W-1:SCORE_W], o10[PATCH_W-1:SCORE_W],
                         o12[PATCH_W-1:SCORE_W], o20[PATCH_W-1:SCORE_W],
                         o21[PATCH_W-1:SCORE_W], o22[PATCH_W-1:SCORE_W]};

  // Asymmetric tie-break: exactly one of a run of equal scores survives.
  assign c_s  = score_of(o11);
  assign surv = o11[CORNER_BIT]
              & (c_s >  score_of(o00)) & (c_s >  score_of(o01))
              & (c_s >  score_of(o02)) & (c_s >  score_of(o10))
              & (c_s >= score_of(o12)) & (c_s >= score_of(o20))
              & (c_s >= score_of(o21)) & (c_s >= score_of(o22));

  // Stage valids: p1 holds the survive decision, p2 requests the FIFO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (ce) begin
      vld_p1_q <= nms_vld & surv;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Stage data follows the valids but carries no reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      kp_p1_q <= kp_of(o11);
      kp_p2_q <= kp_p1_q;
    end
  end

  // ---- FIFO write boundary ----
  assign push   = ce & vld_p2_q;
  assign pop    = kp_ready & ~fifo_empty;
  assign drop   = push & fifo_full & ~pop;
  assign accept = push & ~drop;

  kp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KP_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (kp_p2_q),
    .pop_i   (pop),
    .dout_o  (kp_data),
    .valid_o (kp_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Statistics: a clear applies first, then this cycle's event is counted.
  always_comb begin
    kp_cnt_d   = frame_clr ? '0 : kp_cnt_q;
    drop_cnt_d = frame_clr ? '0 : drop_cnt_q;
    ovf_d      = frame_clr ? 1'b0 : ovf_q;
    kp_cnt_d   = sat_inc(kp_cnt_d, accept);
    drop_cnt_d = sat_inc(drop_cnt_d, drop);
    ovf_d      = ovf_d | drop;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_cnt_q   <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      kp_cnt_q   <= kp_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign kp_cnt   = kp_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign overflow = ovf_q;

endmodule

// File: doc/nms_select.md
NMS_SELECT -- requirements
Module: nms_select

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: output keypoint FIFO depth, power of two, at least 4.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ce  input  1  global enable; the compare pipeline advances only when ce=1.
REQ-006 nms_vld  input  1  the 3x3 patch is valid this cycle.
REQ-007 o00..o22  input  34 each  3x3 patch words; o11 is the centre; field layout per REQ-010.
REQ-008 frame_clr  input  1  synchronous clear of the statistics and the overflow flag.
REQ-009 kp_data  output  33  surviving keypoint, laid out {x(10), y(10), score(13)}.
REQ-010 Patch word fields: [33:24] x_coord, [23:14] y_coord, [13] iscorner, [12:0] score (unsigned).
REQ-011 kp_valid  output  1  kp_data holds a keypoint.
REQ-012 kp_ready  input  1  the consumer accepts the keypoint; a pop happens when kp_valid=1 and kp_ready=1.
REQ-013 kp_cnt  output  CNT_W  keypoints accepted into the FIFO since reset or frame_clr.
REQ-014 drop_cnt  output  CNT_W  keypoints dropped because the FIFO was full.
REQ-015 overflow  output  1  sticky flag; set when a keypoint is dropped.

Function
REQ-016 A patch is sampled on a rising edge where ce=1 and nms_vld=1.
REQ-017 The centre survives when o11.iscorner=1, and o11.score > the scores of o00, o01, o02 and o10, and o11.score >= the scores of o12, o20, o21 and o22. This asymmetric tie-break guarantees exactly one winner among equal neighbours.
REQ-018 Neighbour iscorner bits are ignored; a neighbour with iscorner=0 still takes part in the compare using its score field.
REQ-019 Stage 1 registers the survive bit and {x, y, score} of the centre.
REQ-020 Stage 2 pushes into the FIFO on the next ce=1 edge.
REQ-021 Latency is 2 ce-qualified edges from sample to FIFO write; kp_valid rises on the cycle after the write.
REQ-022 When ce=0, both pipeline stages hold their contents and no push occurs. The FIFO read side and kp_valid are independent of ce.
REQ-023 kp_data and kp_valid are registered outputs of the FIFO. kp_data shall not change while kp_valid=1 and kp_ready=0.
REQ-024 FIFO full with a push and no pop: the keypoint is dropped, drop_cnt increments, overflow is set to 1, and the FIFO contents are unchanged.
REQ-025 FIFO full with a push and a pop in the same cycle: the push is accepted and there is no drop.
REQ-026 FIFO empty: kp_valid=0, and kp_ready is ignored.
REQ-027 FIFO read and write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with one extra pointer bit.
REQ-028 kp_cnt and drop_cnt saturate at 2^CNT_W-1; they do not wrap.
REQ-029 frame_clr=1 zeroes kp_cnt, drop_cnt and overflow. It does not flush the FIFO or the pipeline.
REQ-030 frame_clr together with a push or drop in the same cycle: the counters end at 0 or 1 according to whether this cycle's event is counted; the event of that cycle is counted after the clear.

Reset
REQ-031 rst_n=0 asynchronously clears all of the following: both pipeline valid bits, the FIFO pointers, kp_valid, kp_data, kp_cnt, drop_cnt and overflow.
REQ-032 Assertion of reset mid-frame discards all in-flight and stored keypoints.
REQ-033 After release of rst_n, the first patch may be sampled on the first clk edge with ce=1.
REQ-034 FIFO storage memory has no reset.

Structure
REQ-035 Shared package fast_pkg holds: the patch field positions and widths (X_MSB, Y_MSB, CORNER_BIT, SCORE_W=13, COORD_W=10), the 34-bit patch word width, and a typedef for the 33-bit keypoint word.
REQ-036 The FIFO is a sub-module, kp_fifo, parameterised by depth and width; it provides full, empty, push, pop and the registered output.
REQ-037 The compare logic and the counters reside in nms_select.

Verification
REQ-038 Centre {x=5, y=7, corner=1, score=100}, all neighbours score 50, ce=1, kp_ready=1 -> kp_valid high 2 edges after sampling, kp_data={5, 7, 100}, kp_cnt=1.
REQ-039 Centre score 80 with o02=80 -> suppressed, kp_cnt unchanged. Centre score 80 with o20=80 -> survives.
REQ-040 Centre iscorner=0, score 200, neighbours 0 -> no push.
REQ-041 kp_ready=0, 20 surviving patches, FIFO_DEPTH=16 -> 16 stored, drop_cnt=4, overflow=1. Then kp_ready=1 -> 16 pops in order, then kp_valid=0.
REQ-042 A surviving patch is sampled, then ce=0 for 5 cycles -> no push during the stall; the push occurs on the 2nd ce=1 edge after the sample.
REQ-043 Reset asserted with 3 keypoints queued -> kp_valid=0 immediately and all counters 0. Then frame_clr after drops -> drop_cnt=0 and overflow=0 while FIFO data is retained.
